// File: rtl/dest_reg_pipe_if.sv
// dest_reg_pipe_if
//   Bundle of the destination-tracking pipeline's data and control signals.
//   slave  : the pipeline itself (takes selection/control/operand inputs,
//            drives the stage registers and forwarding results).
//   master : the decode-side driver of those inputs.
//   Signals:
//     src_addr     NSRC*ADDR_W  candidate destination addresses, candidate i at [i*ADDR_W +: ADDR_W]
//     sel          SEL_W        candidate index to capture
//     reg_write_in 1            instruction entering stage 0 writes a register
//     stall        1            hold stage 0, bubble into stage 1
//     flush        1            bubble into stage 0
//     rs_addr      ADDR_W       source operand A address
//     rt_addr      ADDR_W       source operand B address
//     stage_addr   DEPTH*ADDR_W registered destination per stage, stage k at [k*ADDR_W +: ADDR_W]
//     stage_valid  DEPTH        registered write-valid per stage
//     fwd_rs_hit / fwd_rs_idx   nearest valid stage matching rs_addr
//     fwd_rt_hit / fwd_rt_idx   nearest valid stage matching rt_addr
interface dest_reg_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3,
  parameter int IDX_W  = 2
);
  logic [NSRC*ADDR_W-1:0]  src_addr;
  logic [SEL_W-1:0]        sel;
  logic                    reg_write_in;
  logic                    stall;
  logic                    flush;
  logic [ADDR_W-1:0]       rs_addr;
  logic [ADDR_W-1:0]       rt_addr;
  logic [DEPTH*ADDR_W-1:0] stage_addr;
  logic [DEPTH-1:0]        stage_valid;
  logic                    fwd_rs_hit;
  logic [IDX_W-1:0]        fwd_rs_idx;
  logic                    fwd_rt_hit;
  logic [IDX_W-1:0]        fwd_rt_idx;

  modport master (
    output src_addr, sel, reg_write_in, stall, flush, rs_addr, rt_addr,
    input  stage_addr, stage_valid, fwd_rs_hit, fwd_rs_idx, fwd_rt_hit, fwd_rt_idx
  );

  modport slave (
    input  src_addr, sel, reg_write_in, stall, flush, rs_addr, rt_addr,
    output stage_addr, stage_valid, fwd_rs_hit, fwd_rs_idx, fwd_rt_hit, fwd_rt_idx
  );
endinterface

// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe
//   Selects the write-back register address from NSRC candidates and carries
//   it, with its write-valid, through DEPTH stages (0 = EX, 1 = MEM, 2 = WB)
//   under stall/flush control. Produces nearest-stage forwarding matches for
//   the rs and rt source operands from the registered stages only.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears every stage
//     bus    dest_reg_pipe_if.slave (see interface for signal list)
//   DEPTH must be at least 2 (stage 0 and the stall-bubble stage 1).
module dest_reg_pipe #(
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3,
  parameter int IDX_W  = 2
) (
  input  logic           clk,
  input  logic           reset,
  dest_reg_pipe_if.slave bus
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]             valid_q, valid_d;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_in_range;
  logic              new_valid;

  // Candidate select; out-of-range sel yields address 0 and no write.
  always_comb begin
    sel_addr     = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_addr     = bus.src_addr[i*ADDR_W +: ADDR_W];
        sel_in_range = 1'b1;
      end
    end
  end

  // Writes to $0 are never tracked as valid.
  assign new_valid = bus.reg_write_in && sel_in_range && (sel_addr != '0);

  // Stage advance. Flush only affects stage 0; stall freezes stage 0 and
  // bubbles stage 1 even when flush is also set; older stages always shift.
  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;

    if (bus.flush) begin
      addr_d[0]  = '0;
      valid_d[0] = 1'b0;
    end else if (!bus.stall) begin
      addr_d[0]  = sel_addr;
      valid_d[0] = new_valid;
    end

    if (bus.stall) begin
      addr_d[1]  = '0;
      valid_d[1] = 1'b0;
    end else begin
      addr_d[1]  = addr_q[0];
      valid_d[1] = valid_q[0];
    end

    for (int k = 2; k < DEPTH; k++) begin
      addr_d[k]  = addr_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.stage_addr  = addr_q;
  assign bus.stage_valid = valid_q;

  // Nearest valid stage holding the operand address. Scanning from the
  // oldest stage down lets the youngest match overwrite older ones.
  function automatic logic [IDX_W:0] fwd_lookup(
    input logic [ADDR_W-1:0]             src,
    input logic [DEPTH-1:0][ADDR_W-1:0]  addrs,
    input logic [DEPTH-1:0]              valids
  );
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valids[k] && (addrs[k] == src) && (src != '0)) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
    return {hit, idx};
  endfunction

  logic [IDX_W:0] rs_res, rt_res;

  always_comb begin
    rs_res = fwd_lookup(bus.rs_addr, addr_q, valid_q);
    rt_res = fwd_lookup(bus.rt_addr, addr_q, valid_q);
  end

  assign bus.fwd_rs_hit = rs_res[IDX_W];
  assign bus.fwd_rs_idx = rs_res[IDX_W-1:0];
  assign bus.fwd_rt_hit = rt_res[IDX_W];
  assign bus.fwd_rt_idx = rt_res[IDX_W-1:0];

endmodule

// File: tb/tb_dest_reg_pipe.sv
module tb_dest_reg_pipe;
  localparam int ADDR_W = 5;
  localparam int NSRC   = 3;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 3;
  localparam int IDX_W  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_reg_pipe_if #(.ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  dest_reg_pipe #(.ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: list of in-flight instruction records, index 0 = youngest.
  typedef struct {
    int addr;
    bit valid;
  } rec_t;
  rec_t pipe[DEPTH];

  int cand[NSRC];
  int sel_i;
  bit rw, stl, fls;
  int rs, rt;

  task automatic drive();
    bus.src_addr     = {ADDR_W'(cand[2]), ADDR_W'(cand[1]), ADDR_W'(cand[0])};
    bus.sel          = SEL_W'(sel_i);
    bus.reg_write_in = rw;
    bus.stall        = stl;
    bus.flush        = fls;
    bus.rs_addr      = ADDR_W'(rs);
    bus.rt_addr      = ADDR_W'(rt);
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) pipe[k] = '{0, 1'b0};
  endtask

  task automatic model_edge();
    rec_t old[DEPTH];
    rec_t incoming;
    rec_t bubble;
    bubble = '{0, 1'b0};
    old = pipe;
    if (sel_i < NSRC) incoming = '{cand[sel_i], rw && (cand[sel_i] != 0)};
    else              incoming = bubble;
    for (int k = DEPTH - 1; k >= 2; k--) pipe[k] = old[k-1];
    pipe[1] = stl ? bubble : old[0];
    if (fls)      pipe[0] = bubble;
    else if (stl) pipe[0] = old[0];
    else          pipe[0] = incoming;
  endtask

  function automatic int model_fwd(input int a, output bit hit);
    hit = 1'b0;
    if (a == 0) return 0;
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].valid && pipe[k].addr == a) begin
        hit = 1'b1;
        return k;
      end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit h;
    int idx;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("%s addr%0d", tag, k), 32'(bus.stage_addr[k*ADDR_W +: ADDR_W]), 32'(pipe[k].addr));
      chk($sformatf("%s valid%0d", tag, k), 32'(bus.stage_valid[k]), 32'(pipe[k].valid));
    end
    idx = model_fwd(rs, h);
    chk({tag, " rs_hit"}, 32'(bus.fwd_rs_hit), 32'(h));
    chk({tag, " rs_idx"}, 32'(bus.fwd_rs_idx), 32'(idx));
    idx = model_fwd(rt, h);
    chk({tag, " rt_hit"}, 32'(bus.fwd_rt_hit), 32'(h));
    chk({tag, " rt_idx"}, 32'(bus.fwd_rt_idx), 32'(idx));
  endtask

  // Apply current stimulus across one rising edge, then compare.
  task automatic step(input string tag);
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic load(input int a);
    cand = '{a, 0, 0};
    sel_i = 0; rw = 1'b1; stl = 1'b0; fls = 1'b0;
  endtask

  initial begin
    cand = '{0, 0, 0};
    sel_i = 0; rw = 1'b0; stl = 1'b0; fls = 1'b0; rs = 0; rt = 0;
    drive();
    reset = 1'b1;
    model_clear();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Select candidate 1 of {31,12,7} and follow it down the pipe.
    cand = '{7, 12, 31}; sel_i = 1; rw = 1'b1;
    step("sel e1");
    chk("sel s0 addr", 32'(bus.stage_addr[4:0]), 32'd12);
    chk("sel s0 valid", 32'(bus.stage_valid[0]), 32'd1);
    rw = 1'b0; sel_i = 3;
    step("sel e2");
    chk("sel s1 addr", 32'(bus.stage_addr[9:5]), 32'd12);
    step("sel e3");
    chk("sel s2 addr", 32'(bus.stage_addr[14:10]), 32'd12);
    chk("sel s2 valid", 32'(bus.stage_valid[2]), 32'd1);

    // Zero register and out-of-range select.
    cand = '{0, 4, 5}; sel_i = 0; rw = 1'b1;
    step("zero");
    chk("zero s0 valid", 32'(bus.stage_valid[0]), 32'd0);
    sel_i = 3;
    step("oor");
    chk("oor s0 addr", 32'(bus.stage_addr[4:0]), 32'd0);
    chk("oor s0 valid", 32'(bus.stage_valid[0]), 32'd0);

    // Stall twice, then flush together with stall.
    load(9);
    step("ld9");
    rw = 1'b0; stl = 1'b1;
    step("stall1");
    chk("stall1 s0", 32'(bus.stage_addr[4:0]), 32'd9);
    chk("stall1 s1v", 32'(bus.stage_valid[1]), 32'd0);
    step("stall2");
    chk("stall2 s0", 32'(bus.stage_addr[4:0]), 32'd9);
    chk("stall2 s0v", 32'(bus.stage_valid[0]), 32'd1);
    chk("stall2 s1v", 32'(bus.stage_valid[1]), 32'd0);
    fls = 1'b1;
    step("flush+stall");
    chk("fs s0v", 32'(bus.stage_valid[0]), 32'd0);
    chk("fs s1v", 32'(bus.stage_valid[1]), 32'd0);

    // Forwarding priority.
    load(5); rs = 5; rt = 0;
    step("f5a");
    step("f5b");
    step("f5c");
    chk("prio hit", 32'(bus.fwd_rs_hit), 32'd1);
    chk("prio idx0", 32'(bus.fwd_rs_idx), 32'd0);
    rw = 1'b0; stl = 1'b1; fls = 1'b1;
    step("invalidate");
    chk("prio idx2", 32'(bus.fwd_rs_idx), 32'd2);
    chk("prio hit2", 32'(bus.fwd_rs_hit), 32'd1);
    rs = 0; drive(); #1;
    check_all("rs zero");
    chk("rs0 hit", 32'(bus.fwd_rs_hit), 32'd0);

    // Independent operands.
    load(8);
    step("ld8");
    rw = 1'b0; sel_i = 3; rs = 3; rt = 8;
    step("indep");
    chk("indep rt hit", 32'(bus.fwd_rt_hit), 32'd1);
    chk("indep rt idx", 32'(bus.fwd_rt_idx), 32'd1);
    chk("indep rs hit", 32'(bus.fwd_rs_hit), 32'd0);

    // Asynchronous reset mid-cycle with all stages valid.
    load(17); step("full1");
    load(18); step("full2");
    load(19); step("full3");
    rs = 18; rt = 17; drive();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("async reset");
    #1;
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++)
        cand[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      sel_i = int'($urandom_range(0, 3));
      rw  = ($urandom_range(0, 9) < 7);
      stl = ($urandom_range(0, 9) < 2);
      fls = ($urandom_range(0, 9) < 2);
      step($sformatf("rnd%0d", n));
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : pipe[$urandom_range(0, DEPTH-1)].addr;
      rt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : pipe[$urandom_range(0, DEPTH-1)].addr;
      drive();
      #1;
      check_all($sformatf("rndfwd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
